// File: rtl/dht11_scheduler.sv
// Periodic / on-demand read sequencer for the DHT11 reader with retries, hung-read timeout and held results.
// Optional DHT_SCHED_RANGE_CHECK_EN: implausible readings (umidade > 100, temperatura > 60) count as errors.
//
// state   | meaning
// IDLE    | nothing scheduled, waiting for enable or a pending force
// START   | one-cycle start pulse to the reader
// GUARD   | one cycle ignoring stale pronto/error flags
// WAIT    | waiting for pronto, error or timeout
// HOLDOFF | enforcing the sensor gap measured from the last start
module dht11_scheduler #(
  parameter int PERIOD_CYCLES    = 100000000,
  parameter int RETRY_GAP_CYCLES = 50000000,
  parameter int TIMEOUT_CYCLES   = 2500000,
  parameter int MAX_RETRIES      = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        force_read,
  output logic        sensor_start,
  input  logic        sensor_pronto,
  input  logic        sensor_error,
  input  logic [15:0] sensor_temperatura,
  input  logic [15:0] sensor_umidade,
  output logic [15:0] temperatura,
  output logic [15:0] umidade,
  output logic        valid,
  output logic        fail,
  output logic        new_sample,
  output logic [2:0]  attempt,
  output logic [2:0]  db_estado
);

  localparam int GAP_MAX = (PERIOD_CYCLES > RETRY_GAP_CYCLES) ? PERIOD_CYCLES : RETRY_GAP_CYCLES;
  localparam int IW      = $clog2(GAP_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    GUARD   = 3'd2,
    WAIT    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [IW-1:0] interval_cnt;
  logic [IW-1:0] limit;
  logic [TW-1:0] timeout_cnt;
  logic          pending;
  logic          out_of_range;
  logic          accept;
  logic          reject;
  logic          gap_done;
  logic          retry_left;

`ifdef DHT_SCHED_RANGE_CHECK_EN
  assign out_of_range = (sensor_umidade[15:8] > 8'd100) || (sensor_temperatura[15:8] > 8'd60);
`else
  assign out_of_range = 1'b0;
`endif

  assign accept     = sensor_pronto && !out_of_range;
  assign reject     = (sensor_pronto && out_of_range) || sensor_error
                      || (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
  // interval_cnt holds the number of cycles since the start pulse
  assign gap_done   = interval_cnt >= (limit - IW'(1));
  assign retry_left = attempt < 3'(MAX_RETRIES);

  assign sensor_start = (state == START);
  assign db_estado    = state;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (enable || pending) state_d = START;
      START:   state_d = GUARD;
      GUARD:   state_d = WAIT;
      WAIT:    if (accept || reject) state_d = HOLDOFF;
      HOLDOFF: begin
        if (gap_done) begin
          if ((attempt != 3'd0) || enable || pending) state_d = START;
          else                                        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      interval_cnt <= '0;
      limit        <= '0;
      timeout_cnt  <= '0;
      pending      <= 1'b0;
      temperatura  <= 16'd0;
      umidade      <= 16'd0;
      valid        <= 1'b0;
      fail         <= 1'b0;
      new_sample   <= 1'b0;
      attempt      <= 3'd0;
    end else begin
      state      <= state_d;
      new_sample <= 1'b0;

      // a force arriving as a start is launched is served by that start
      if ((state_d == START) && (state != START)) pending <= 1'b0;
      else if (force_read && (state != START))    pending <= 1'b1;

      if (state == START)
        interval_cnt <= IW'(1);
      else if ((state == GUARD) || (state == WAIT) || ((state == HOLDOFF) && (interval_cnt < limit)))
        interval_cnt <= interval_cnt + IW'(1);

      if (state == GUARD)     timeout_cnt <= '0;
      else if (state == WAIT) timeout_cnt <= timeout_cnt + TW'(1);

      if (state == WAIT) begin
        if (accept) begin
          temperatura <= sensor_temperatura;
          umidade     <= sensor_umidade;
          valid       <= 1'b1;
          fail        <= 1'b0;
          attempt     <= 3'd0;
          new_sample  <= 1'b1;
          limit       <= IW'(PERIOD_CYCLES);
        end else if (reject) begin
          if (retry_left) begin
            attempt <= attempt + 3'd1;
            limit   <= IW'(RETRY_GAP_CYCLES);
          end else begin
            fail    <= 1'b1;
            attempt <= 3'd0;
            limit   <= IW'(PERIOD_CYCLES);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dht11_scheduler.sv
// Bench for dht11_scheduler: timeline-level reference model checked every cycle, a scripted
// sensor responder, and directed scenarios with hand-computed expectations.
module tb_dht11_scheduler;

  localparam int P = 200;
  localparam int R = 80;
  localparam int T = 40;
  localparam int M = 2;

  localparam logic [1:0] K_OK = 2'd0, K_ERR = 2'd1, K_SILENT = 2'd2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        force_read = 1'b0;
  logic        sensor_start;
  logic        sensor_pronto = 1'b0;
  logic        sensor_error = 1'b0;
  logic [15:0] sensor_temperatura = 16'd0;
  logic [15:0] sensor_umidade = 16'd0;
  logic [15:0] temperatura, umidade;
  logic        valid, fail, new_sample;
  logic [2:0]  attempt, db_estado;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  dht11_scheduler #(
    .PERIOD_CYCLES(P), .RETRY_GAP_CYCLES(R), .TIMEOUT_CYCLES(T), .MAX_RETRIES(M)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .force_read(force_read),
    .sensor_start(sensor_start), .sensor_pronto(sensor_pronto), .sensor_error(sensor_error),
    .sensor_temperatura(sensor_temperatura), .sensor_umidade(sensor_umidade),
    .temperatura(temperatura), .umidade(umidade), .valid(valid), .fail(fail),
    .new_sample(new_sample), .attempt(attempt), .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scripted sensor: answers 10 cycles after each start ----------------
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] t;
    logic [15:0] u;
  } resp_t;

  resp_t resp_q[$];
  resp_t s_r;
  int    s_age = 0;
  bit    s_active = 1'b0;

  task automatic push(input logic [1:0] kind, input logic [15:0] t, input logic [15:0] u);
    resp_q.push_back('{kind: kind, t: t, u: u});
  endtask

  always @(negedge clock or posedge reset) begin
    if (reset) begin
      sensor_pronto = 1'b0;
      sensor_error  = 1'b0;
      s_active      = 1'b0;
    end else if (sensor_start) begin
      sensor_pronto = 1'b0;
      sensor_error  = 1'b0;
      s_active      = 1'b1;
      s_age         = 0;
      if (resp_q.size() > 0) s_r = resp_q.pop_front();
      else                   s_r = '{kind: K_OK, t: 16'h1400, u: 16'h3200};
    end else if (s_active) begin
      s_age++;
      if (s_age == 10) begin
        s_active = 1'b0;
        if (s_r.kind == K_OK) begin
          sensor_temperatura = s_r.t;
          sensor_umidade     = s_r.u;
          sensor_pronto      = 1'b1;
        end else if (s_r.kind == K_ERR) begin
          sensor_error = 1'b1;
        end
      end
    end
  end

  // ---------------- reference model: timeline of reads, gaps and results ----------------
  function automatic bit implausible(input logic [15:0] t, input logic [15:0] u);
`ifdef DHT_SCHED_RANGE_CHECK_EN
    return (u[15:8] > 8'd100) || (t[15:8] > 8'd60);
`else
    return (t === 16'hxxxx) && (u === 16'hxxxx);
`endif
  endfunction

  int          m_now = 0;
  bit          m_fl, m_hold, m_pend, m_valid, m_fail, m_ns, m_launch, m_starting;
  int          m_age, m_start, m_deadline, m_att;
  logic [15:0] m_t, m_u;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_fl = 0; m_hold = 0; m_pend = 0; m_valid = 0; m_fail = 0; m_ns = 0;
      m_age = 0; m_start = 0; m_deadline = 0; m_att = 0; m_t = 0; m_u = 0;
    end else begin
      m_starting = m_fl && (m_age == 0);
      m_launch   = 0;
      m_ns       = 0;
      if (m_fl) begin
        if (m_age >= 2 && sensor_pronto && !implausible(sensor_temperatura, sensor_umidade)) begin
          m_t = sensor_temperatura; m_u = sensor_umidade;
          m_valid = 1; m_fail = 0; m_att = 0; m_ns = 1;
          m_deadline = m_start + P;
          m_fl = 0; m_hold = 1;
        end else if (m_age >= 2 && (sensor_pronto || sensor_error || m_age == T + 1)) begin
          if (m_att < M) begin m_att++; m_deadline = m_start + R; end
          else begin m_fail = 1; m_att = 0; m_deadline = m_start + P; end
          m_fl = 0; m_hold = 1;
        end else begin
          m_age++;
        end
      end else if (m_now + 1 >= m_deadline) begin
        m_hold = 0;
        if (m_att != 0 || enable || m_pend) m_launch = 1;
      end
      if (m_launch) begin
        m_fl = 1; m_age = 0; m_start = m_now + 1; m_pend = 0;
      end else if (force_read && !m_starting) begin
        m_pend = 1;
      end
      m_now++;
    end
  end

  function automatic logic [31:0] exp_db();
    if (m_fl) return (m_age == 0) ? 32'd1 : (m_age == 1) ? 32'd2 : 32'd3;
    return m_hold ? 32'd4 : 32'd0;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      check("sensor_start", 32'(sensor_start), 32'(m_fl && (m_age == 0)));
      check("db_estado",    32'(db_estado),    exp_db());
      check("temperatura",  32'(temperatura),  32'(m_t));
      check("umidade",      32'(umidade),      32'(m_u));
      check("valid",        32'(valid),        32'(m_valid));
      check("fail",         32'(fail),         32'(m_fail));
      check("attempt",      32'(attempt),      m_att);
      check("new_sample",   32'(new_sample),   32'(m_ns));
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_start(input int budget, output int t, output int att);
    t   = -1;
    att = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (sensor_start) begin
        t   = cyc;
        att = 32'(attempt);
        break;
      end
    end
    tests++;
    if (t < 0) begin
      fails++;
      $display("FAIL wait_start: no sensor_start within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  task automatic count_starts(input int span, output int n);
    n = 0;
    for (int i = 0; i < span; i++) begin
      @(negedge clock);
      force_read = 1'b0;
      if (sensor_start) n++;
    end
  endtask

  int s1, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11, a, n;

  initial begin
    repeat (3) @(negedge clock);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_start", 32'(sensor_start), 32'd0);
    check("rst_state", 32'(db_estado), 32'd0);

    // periodic success
    push(K_OK, 16'h1900, 16'h3700);
    enable = 1'b1;
    reset  = 1'b0;
    wait_start(10, s1, a);
    repeat (10) @(negedge clock);
    check("pre_latch_temp", 32'(temperatura), 32'h0);
    check("pre_latch_ns", 32'(new_sample), 32'd0);
    @(negedge clock);
    check("ok_temp", 32'(temperatura), 32'h1900);
    check("ok_umid", 32'(umidade), 32'h3700);
    check("ok_valid", 32'(valid), 32'd1);
    check("ok_ns_on", 32'(new_sample), 32'd1);
    @(negedge clock);
    check("ok_ns_off", 32'(new_sample), 32'd0);

    // two errors then success
    push(K_ERR, 16'h0, 16'h0);
    push(K_ERR, 16'h0, 16'h0);
    push(K_OK, 16'h1a00, 16'h3800);
    wait_start(250, s2, a);
    check("period_gap", s2 - s1, P);
    wait_start(100, s3, a);
    check("retry_gap1", s3 - s2, R);
    check("retry_att1", a, 1);
    wait_start(100, s4, a);
    check("retry_gap2", s4 - s3, R);
    check("retry_att2", a, 2);
    repeat (11) @(negedge clock);
    check("retry_temp", 32'(temperatura), 32'h1a00);
    check("retry_att0", 32'(attempt), 32'd0);
    check("retry_fail", 32'(fail), 32'd0);

    // silent sensor: three timeouts then fail
    push(K_SILENT, 16'h0, 16'h0);
    push(K_SILENT, 16'h0, 16'h0);
    push(K_SILENT, 16'h0, 16'h0);
    wait_start(250, s5, a);
    check("gap_after_ok", s5 - s4, P);
    wait_start(100, s6, a);
    check("to_gap1", s6 - s5, R);
    wait_start(100, s7, a);
    check("to_gap2", s7 - s6, R);
    repeat (41) @(negedge clock);
    check("to_not_yet", 32'(fail), 32'd0);
    @(negedge clock);
    check("to_fail", 32'(fail), 32'd1);
    check("to_keep_temp", 32'(temperatura), 32'h1a00);
    check("to_keep_valid", 32'(valid), 32'd1);

    // success with enable dropped, then force inside holdoff
    push(K_OK, 16'h1b00, 16'h3900);
    wait_start(250, s8, a);
    check("gap_after_fail", s8 - s7, P);
    enable = 1'b0;
    repeat (11) @(negedge clock);
    check("late_temp", 32'(temperatura), 32'h1b00);
    check("late_fail", 32'(fail), 32'd0);
    repeat (89) @(negedge clock);
    push(K_OK, 16'h1c00, 16'h3a00);
    force_read = 1'b1;
    @(negedge clock);
    force_read = 1'b0;
    wait_start(150, s9, a);
    check("force_holdoff_gap", s9 - s8, P);
    repeat (205) @(negedge clock);
    check("back_idle", 32'(db_estado), 32'd0);

    // force in IDLE: exactly one read
    push(K_OK, 16'h1500, 16'h3300);
    force_read = 1'b1;
    count_starts(1000, n);
    check("force_idle_starts", n, 1);

    // reset while waiting
    push(K_SILENT, 16'h0, 16'h0);
    enable = 1'b1;
    wait_start(10, s10, a);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_temp", 32'(temperatura), 32'd0);
    check("rst_umid", 32'(umidade), 32'd0);
    check("rst_valid2", 32'(valid), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_attempt", 32'(attempt), 32'd0);
    check("rst_db", 32'(db_estado), 32'd0);
    check("rst_start2", 32'(sensor_start), 32'd0);
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    count_starts(300, n);
    check("post_rst_quiet", n, 0);

    // implausible humidity
    push(K_OK, 16'h1900, 16'h7800);
    enable = 1'b1;
    wait_start(10, s11, a);
    enable = 1'b0;
    repeat (11) @(negedge clock);
`ifdef DHT_SCHED_RANGE_CHECK_EN
    check("range_att", 32'(attempt), 32'd1);
    check("range_valid", 32'(valid), 32'd0);
    check("range_umid", 32'(umidade), 32'd0);
`else
    check("range_att", 32'(attempt), 32'd0);
    check("range_valid", 32'(valid), 32'd1);
    check("range_umid", 32'(umidade), 32'h7800);
`endif
    repeat (300) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
